// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core LSU (port 0)
// and the debug/program loader (port 1); one transaction at a time, reads wait out RD_LAT.
module dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_req,
  input  logic [1:0]      i_wren,
  input  logic [AW-1:0]   i_addr0,
  input  logic [AW-1:0]   i_addr1,
  input  logic [DW-1:0]   i_wdata0,
  input  logic [DW-1:0]   i_wdata1,
  input  logic [DW/8-1:0] i_bmask0,
  input  logic [DW/8-1:0] i_bmask1,
  output logic [1:0]      o_gnt,
  output logic [1:0]      o_rvld,
  output logic [DW-1:0]   o_rdata,
  output logic            o_busy,
  output logic            o_core_stall,
  output logic            o_mem_en,
  output logic            o_mem_wren,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_bmask,
  input  logic [DW-1:0]   i_mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t          state, state_nxt;
  logic            rr_ptr, rr_ptr_nxt;
  logic            owner, owner_nxt;
  logic [1:0]      cnt, cnt_nxt;
  logic [1:0]      rvld_q, rvld_nxt;
  logic [DW-1:0]   rdata_q, rdata_nxt;
  logic [1:0]      elig;
  logic            any_req;
  logic            winner;

  // A port whose read data is returning this cycle may not be granted in the same cycle.
  assign elig    = i_req & ~rvld_q;
  assign any_req = |elig;
  assign winner  = (elig == 2'b11) ? rr_ptr : elig[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      owner   <= 1'b0;
      cnt     <= '0;
      rvld_q  <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      owner   <= owner_nxt;
      cnt     <= cnt_nxt;
      rvld_q  <= rvld_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    rvld_nxt   = '0;
    rdata_nxt  = rdata_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (elig == 2'b11)
            rr_ptr_nxt = ~winner;
          if (!i_wren[winner]) begin
            state_nxt = RD_WAIT;
            cnt_nxt   = CNT_INIT;
            owner_nxt = winner;
          end
        end
      end
      RD_WAIT: begin
        if (cnt == 2'd0) begin
          rdata_nxt       = i_mem_rdata;
          rvld_nxt[owner] = 1'b1;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_gnt       = '0;
    o_mem_en    = 1'b0;
    if (state == IDLE && any_req) begin
      o_gnt[winner] = 1'b1;
      o_mem_en      = 1'b1;
    end
    o_mem_wren   = o_mem_en & i_wren[winner];
    o_mem_addr   = winner ? i_addr1  : i_addr0;
    o_mem_wdata  = winner ? i_wdata1 : i_wdata0;
    o_mem_bmask  = winner ? i_bmask1 : i_bmask0;
    o_rvld       = rvld_q;
    o_rdata      = rdata_q;
    o_busy       = (state == RD_WAIT);
    o_core_stall = (i_req[0] & ~(o_gnt[0] & i_wren[0])) | ((state == RD_WAIT) && !owner);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: three instances (RD_LAT 1, 3, 4) share stimulus;
// the instance selected by 'sel' is checked against expected grant/read-return events.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, wren;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  bmask0, bmask1;

  logic [1:0]  gnt_a    [3];
  logic [1:0]  rvld_a   [3];
  logic [31:0] rdata_a  [3];
  logic        busy_a   [3];
  logic        stall_a  [3];
  logic        en_a     [3];
  logic        mwren_a  [3];
  logic [31:0] maddr_a  [3];
  logic [31:0] mwdata_a [3];
  logic [3:0]  mbmask_a [3];

  int sel = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int c;

  typedef struct {
    bit          is_rvld;
    bit          port;
    int          cyc;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bmask;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    logic [31:0] pipe [L];
    logic [31:0] mrd;

    // Memory model: returns memf(addr) exactly L cycles after the address is presented.
    always @(posedge clk) begin
      pipe[0] <= memf(maddr_a[g]);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mrd = pipe[L-1];

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(L)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req        (req),
      .i_wren       (wren),
      .i_addr0      (addr0),
      .i_addr1      (addr1),
      .i_wdata0     (wdata0),
      .i_wdata1     (wdata1),
      .i_bmask0     (bmask0),
      .i_bmask1     (bmask1),
      .o_gnt        (gnt_a[g]),
      .o_rvld       (rvld_a[g]),
      .o_rdata      (rdata_a[g]),
      .o_busy       (busy_a[g]),
      .o_core_stall (stall_a[g]),
      .o_mem_en     (en_a[g]),
      .o_mem_wren   (mwren_a[g]),
      .o_mem_addr   (maddr_a[g]),
      .o_mem_wdata  (mwdata_a[g]),
      .o_mem_bmask  (mbmask_a[g]),
      .i_mem_rdata  (mrd)
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d, dut %0d)", name, act, exp, cyc, sel);
  endtask

  task automatic checkEvent(input bit is_rvld);
    ev_t e;
    logic [1:0] v;
    v = is_rvld ? rvld_a[sel] : gnt_a[sel];
    if (sb.size() == 0) begin
      n_checks++;
      $display("[TB] FAIL unexpected_%s: got 0x%0h, expected no event (cycle %0d)",
               is_rvld ? "rvld" : "gnt", v, cyc);
      return;
    end
    e = sb.pop_front();
    checkOutput(is_rvld ? "rvld_kind" : "gnt_kind", 32'(is_rvld), 32'(e.is_rvld));
    checkOutput(is_rvld ? "rvld_port" : "gnt_port", 32'(v), 32'(2'b01 << e.port));
    checkOutput(is_rvld ? "rvld_cycle" : "gnt_cycle", cyc, e.cyc);
    if (is_rvld) begin
      checkOutput("rdata", rdata_a[sel], e.data);
    end else begin
      checkOutput("mem_en", 32'(en_a[sel]), 32'd1);
      checkOutput("mem_wren", 32'(mwren_a[sel]), 32'(e.wr));
      checkOutput("mem_addr", maddr_a[sel], e.addr);
      checkOutput("mem_bmask", 32'(mbmask_a[sel]), 32'(e.bmask));
      if (e.wr) checkOutput("mem_wdata", mwdata_a[sel], e.data);
    end
  endtask

  // Monitor: read returns are checked before grants in a cycle where both occur.
  always @(negedge clk) begin
    if (rvld_a[sel] != 2'b00) checkEvent(1'b1);
    if (gnt_a[sel]  != 2'b00) checkEvent(1'b0);
  end

  task automatic expectGnt(input bit port, input int cy, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] bm);
    sb.push_back('{1'b0, port, cy, wr, a, d, bm});
  endtask

  task automatic expectRvld(input bit port, input int cy, input logic [31:0] d);
    sb.push_back('{1'b1, port, cy, 1'b0, 32'h0, d, 4'h0});
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [3:0] b0, input logic [3:0] b1);
    req = r; wren = w; addr0 = a0; addr1 = a1;
    wdata0 = d0; wdata1 = d1; bmask0 = b0; bmask1 = b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int s);
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    step();
    sel = s;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    doReset(0);
    @(negedge clk);
    checkOutput("rst_gnt",   32'(gnt_a[0]), 32'd0);
    checkOutput("rst_rvld",  32'(rvld_a[0]), 32'd0);
    checkOutput("rst_busy",  32'(busy_a[0]), 32'd0);
    checkOutput("rst_memen", 32'(en_a[0]), 32'd0);
    checkOutput("rst_rdata", rdata_a[0], 32'd0);
    checkOutput("rst_stall", 32'(stall_a[0]), 32'd0);
    step();

    // (1) RD_LAT=1 port-0 load
    $display("[TB] test 1: single load");
    c = cyc;
    applyStimulus(2'b01, 2'b00, 32'h100, 0, 0, 0, 4'h0, 4'h0);
    expectGnt(1'b0, c, 1'b0, 32'h100, 0, 4'h0);
    expectRvld(1'b0, c + 2, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t1_stall_gnt", 32'(stall_a[0]), 32'd1);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    @(negedge clk);
    checkOutput("t1_busy_wait",  32'(busy_a[0]), 32'd1);
    checkOutput("t1_stall_wait", 32'(stall_a[0]), 32'd1);
    step();
    @(negedge clk);
    checkOutput("t1_busy_ret",  32'(busy_a[0]), 32'd0);
    checkOutput("t1_stall_ret", 32'(stall_a[0]), 32'd0);
    step();
    @(negedge clk);
    checkOutput("t1_rdata_hold", rdata_a[0], 32'hDEADBEEF);
    checkOutput("t1_rvld_off", 32'(rvld_a[0]), 32'd0);

    // (2) both ports storing every cycle
    $display("[TB] test 2: back-to-back stores");
    doReset(0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 2'b11, 32'h200 + 32'(4*i), 32'h300 + 32'(4*i),
                    32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 4'hF, 4'h3);
      if (i % 2 == 0) expectGnt(1'b0, cyc, 1'b1, addr0, wdata0, 4'hF);
      else            expectGnt(1'b1, cyc, 1'b1, addr1, wdata1, 4'h3);
      @(negedge clk);
      checkOutput("t2_mem_en", 32'(en_a[0]), 32'd1);
      step();
    end
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);

    // (3) port-0 request arrives while port 1 read is outstanding
    $display("[TB] test 3: request during read wait");
    doReset(0);
    c = cyc;
    applyStimulus(2'b10, 2'b00, 0, 32'h400, 0, 0, 4'h0, 4'h0);
    expectGnt(1'b1, c, 1'b0, 32'h400, 0, 4'h0);
    expectRvld(1'b1, c + 2, 32'hDEADBBEF);
    step();
    applyStimulus(2'b01, 2'b01, 32'h500, 0, 32'hCAFE0000, 0, 4'hC, 4'h0);
    expectGnt(1'b0, c + 2, 1'b1, 32'h500, 32'hCAFE0000, 4'hC);
    @(negedge clk);
    checkOutput("t3_stall_wait", 32'(stall_a[0]), 32'd1);
    step();
    @(negedge clk);
    checkOutput("t3_stall_done", 32'(stall_a[0]), 32'd0);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    step();

    // (4) reset mid-read, RD_LAT=3
    $display("[TB] test 4: reset during read");
    doReset(1);
    applyStimulus(2'b11, 2'b11, 32'h700, 32'h704, 32'h1, 32'h2, 4'hF, 4'hF);
    expectGnt(1'b0, cyc, 1'b1, 32'h700, 32'h1, 4'hF);
    step();
    applyStimulus(2'b01, 2'b00, 32'h600, 0, 0, 0, 4'h0, 4'h0);
    expectGnt(1'b0, cyc, 1'b0, 32'h600, 0, 4'h0);
    step();
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    @(negedge clk);
    checkOutput("t4_busy_pre", 32'(busy_a[1]), 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4_busy_post",  32'(busy_a[1]), 32'd0);
    checkOutput("t4_memen_post", 32'(en_a[1]), 32'd0);
    repeat (5) step();
    applyStimulus(2'b11, 2'b11, 32'h710, 32'h714, 32'h3, 32'h4, 4'hF, 4'hF);
    expectGnt(1'b0, cyc, 1'b1, 32'h710, 32'h3, 4'hF);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    step();

    // (5) RD_LAT=4 load followed by a store from the same port
    $display("[TB] test 5: load then store");
    doReset(2);
    c = cyc;
    applyStimulus(2'b01, 2'b00, 32'h800, 0, 0, 0, 4'h0, 4'h0);
    expectGnt(1'b0, c, 1'b0, 32'h800, 0, 4'h0);
    expectRvld(1'b0, c + 5, 32'hDEADB7EF);
    expectGnt(1'b0, c + 6, 1'b1, 32'h804, 32'h12345678, 4'h5);
    step();
    applyStimulus(2'b01, 2'b01, 32'h804, 0, 32'h12345678, 0, 4'h5, 4'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("t5_stall_pend", 32'(stall_a[2]), 32'd1);
      step();
    end
    @(negedge clk);
    checkOutput("t5_stall_store", 32'(stall_a[2]), 32'd0);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    step();

    // (6) port-1 request abandoned while port 0 read is outstanding
    $display("[TB] test 6: abandoned request");
    doReset(0);
    c = cyc;
    applyStimulus(2'b01, 2'b00, 32'hA00, 0, 0, 0, 4'h0, 4'h0);
    expectGnt(1'b0, c, 1'b0, 32'hA00, 0, 4'h0);
    expectRvld(1'b0, c + 2, 32'hDEADB5EF);
    step();
    applyStimulus(2'b10, 2'b00, 0, 32'hB00, 0, 0, 4'h0, 4'h0);
    @(negedge clk);
    checkOutput("t6_memen_wait", 32'(en_a[0]), 32'd0);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    @(negedge clk);
    checkOutput("t6_memen_drop", 32'(en_a[0]), 32'd0);
    repeat (4) step();

    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      n_checks++;
      $display("[TB] FAIL missing_%s: got nothing, expected port %0d at cycle %0d",
               e.is_rvld ? "rvld" : "gnt", e.port, e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
